// File: rtl/input_debouncer_pkg.sv
// Shared defaults and width helpers for the front-panel input debouncer.
// Imported by debounce_bit and input_debouncer.
package input_debouncer_pkg;

  localparam int NUM_USER_INPUTS  = 14;
  localparam int DEF_TICK_DIV     = 100_000;
  localparam int DEF_STABLE_TICKS = 8;

  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

  // A divide-by-one prescaler still needs a 1-bit counter.
  function automatic int pcnt_width(input int tick_div);
    return (tick_div > 1) ? $clog2(tick_div) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounced line: 2-flop synchroniser, stability counter,
// committed level and single-cycle rise/fall events.
module debounce_bit
  import input_debouncer_pkg::*;
#(
  parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
  parameter logic RESET_VAL    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // A sample matching the committed level discards any partial count.
  always_comb begin
    commit = 1'b0;
    cnt_nx = cnt;
    if (tick) begin
      if (s2 == db) begin
        cnt_nx = '0;
      end else if (cnt == LAST) begin
        commit = 1'b1;
        cnt_nx = '0;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      db   <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      cnt  <= cnt_nx;
      rise <= commit & s2;
      fall <= commit & ~s2;
      if (commit) begin
        db <= s2;
      end
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Front-panel input debouncer: shared sample prescaler feeding
// WIDTH independent debounce_bit lanes.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int               WIDTH        = NUM_USER_INPUTS,
  parameter int               TICK_DIV     = DEF_TICK_DIV,
  parameter int               STABLE_TICKS = DEF_STABLE_TICKS,
  parameter logic [WIDTH-1:0] RESET_VAL    = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int PW = pcnt_width(TICK_DIV);
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS),
      .RESET_VAL   (RESET_VAL[i])
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .raw  (raw_in[i]),
      .db   (db_out[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed self-checking bench for input_debouncer with a
// cycle-accurate reference model compared every cycle.
module tb_input_debouncer;

  localparam int W  = 14;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] raw_in = '1;
  logic [W-1:0] db_out;
  logic [W-1:0] rise;
  logic [W-1:0] fall;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  input_debouncer #(
    .WIDTH       (W),
    .TICK_DIV    (TD),
    .STABLE_TICKS(ST),
    .RESET_VAL   (14'h3FFF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_in(raw_in),
    .db_out(db_out),
    .rise  (rise),
    .fall  (fall)
  );

  // Reference model
  logic [W-1:0] m_s1, m_s2, m_db, m_rise, m_fall;
  int           m_cnt [W];
  int           m_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1   <= '1;
      m_s2   <= '1;
      m_db   <= '1;
      m_rise <= '0;
      m_fall <= '0;
      m_p    <= 0;
      for (int i = 0; i < W; i++) m_cnt[i] <= 0;
    end else begin
      m_s1   <= raw_in;
      m_s2   <= m_s1;
      m_p    <= (m_p == TD - 1) ? 0 : m_p + 1;
      m_rise <= '0;
      m_fall <= '0;
      if (m_p == TD - 1) begin
        for (int i = 0; i < W; i++) begin
          if (m_s2[i] == m_db[i]) begin
            m_cnt[i] <= 0;
          end else if (m_cnt[i] + 1 == ST) begin
            m_cnt[i] <= 0;
            m_db[i]  <= m_s2[i];
            if (m_s2[i]) m_rise[i] <= 1'b1;
            else         m_fall[i] <= 1'b1;
          end else begin
            m_cnt[i] <= m_cnt[i] + 1;
          end
        end
      end
    end
  end

  task automatic test_reset();
    for (int c = 0; c < 20; c++) begin
      raw_in = 14'($urandom);
      @(negedge clk);
      vectors++;
      if (db_out !== 14'h3FFF || rise !== '0 || fall !== '0) begin
        miscompares++;
        $display("FAIL reset_hold c=%0d db=%h rise=%h fall=%h want db=3fff rise=0 fall=0",
                 c, db_out, rise, fall);
      end
    end
    raw_in = '1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++;
      if (db_out !== 14'h3FFF || rise !== '0 || fall !== '0) begin
        miscompares++;
        $display("FAIL reset_release c=%0d db=%h rise=%h fall=%h want db=3fff no pulses",
                 c, db_out, rise, fall);
      end
    end
  endtask

  task automatic test_clean_press();
    int first = -1;
    int nf = 0;
    int nr = 0;
    raw_in[0] = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      vectors++;
      if (db_out !== m_db || rise !== m_rise || fall !== m_fall) begin
        miscompares++;
        $display("FAIL press_model n=%0d db=%h rise=%h fall=%h want %h %h %h",
                 n, db_out, rise, fall, m_db, m_rise, m_fall);
      end
      if (first < 0 && db_out[0] === 1'b0) first = n;
      if (fall[0] === 1'b1) nf++;
      if (rise !== '0) nr++;
    end
    vectors++;
    if (first < 9 || first > 14) begin
      miscompares++;
      $display("FAIL press_latency got %0d want 9..14", first);
    end
    vectors++;
    if (nf != 1 || nr != 0) begin
      miscompares++;
      $display("FAIL press_pulses fall=%0d rise=%0d want 1 0", nf, nr);
    end
    raw_in[0] = 1'b1;
    for (int n = 0; n < 20; n++) @(negedge clk);
    vectors++;
    if (db_out !== 14'h3FFF) begin
      miscompares++;
      $display("FAIL press_restore db=%h want 3fff", db_out);
    end
  endtask

  task automatic test_bounce();
    int nb = 0;
    int nf = 0;
    int nr = 0;
    for (int k = 0; k < 48; k++) begin
      if (k % 3 == 0) raw_in[5] = ~raw_in[5];
      @(negedge clk);
      vectors++;
      if (db_out !== m_db || rise !== m_rise || fall !== m_fall) begin
        miscompares++;
        $display("FAIL bounce_model k=%0d db=%h rise=%h fall=%h want %h %h %h",
                 k, db_out, rise, fall, m_db, m_rise, m_fall);
      end
      if (rise[5] === 1'b1 || fall[5] === 1'b1 || db_out[5] !== 1'b1) nb++;
    end
    vectors++;
    if (nb != 0) begin
      miscompares++;
      $display("FAIL bounce_quiet events=%0d want 0", nb);
    end
    raw_in[5] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (fall[5] === 1'b1) nf++;
      if (rise[5] === 1'b1) nr++;
    end
    vectors++;
    if (nf != 1 || nr != 0 || db_out[5] !== 1'b0) begin
      miscompares++;
      $display("FAIL bounce_settle fall=%0d rise=%0d db5=%b want 1 0 0", nf, nr, db_out[5]);
    end
    nf = 0;
    nr = 0;
    raw_in[5] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (fall[5] === 1'b1) nf++;
      if (rise[5] === 1'b1) nr++;
    end
    vectors++;
    if (nr != 1 || nf != 0 || db_out[5] !== 1'b1) begin
      miscompares++;
      $display("FAIL bounce_release rise=%0d fall=%0d db5=%b want 1 0 1", nr, nf, db_out[5]);
    end
  endtask

  task automatic test_glitch();
    int bad = 0;
    raw_in[2] = 1'b0;
    for (int k = 0; k < 36; k++) begin
      if (k == 6) raw_in[2] = 1'b1;
      @(negedge clk);
      vectors++;
      if (db_out !== m_db || rise !== m_rise || fall !== m_fall) begin
        miscompares++;
        $display("FAIL glitch_model k=%0d db=%h rise=%h fall=%h want %h %h %h",
                 k, db_out, rise, fall, m_db, m_rise, m_fall);
      end
      if (db_out[2] !== 1'b1 || rise[2] !== 1'b0 || fall[2] !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL glitch_reject bad_cycles=%0d want 0", bad);
    end
  endtask

  task automatic test_simultaneous();
    int hits = 0;
    int other = 0;
    logic [W-1:0] want;
    want = '0;
    want[3] = 1'b1;
    want[10] = 1'b1;
    raw_in[3] = 1'b0;
    raw_in[10] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (fall === want) hits++;
      else if (fall !== '0) other++;
      if (rise !== '0) other++;
    end
    vectors++;
    if (hits != 1 || other != 0) begin
      miscompares++;
      $display("FAIL simul_fall hits=%0d stray=%0d want 1 0", hits, other);
    end
    vectors++;
    if (db_out !== (14'h3FFF & ~want)) begin
      miscompares++;
      $display("FAIL simul_level db=%h want %h", db_out, 14'h3FFF & ~want);
    end
    raw_in[3] = 1'b1;
    raw_in[10] = 1'b1;
    for (int k = 0; k < 30; k++) @(negedge clk);
  endtask

  task automatic test_reset_midcount();
    int to = 0;
    int first = -1;
    int nf = 0;
    raw_in[7] = 1'b0;
    while (m_cnt[7] != 2 && to < 40) begin
      @(negedge clk);
      to++;
    end
    vectors++;
    if (to >= 40) begin
      miscompares++;
      $display("FAIL midcnt_wait timeout after %0d cycles", to);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (db_out[7] !== 1'b1 || fall !== '0 || rise !== '0) begin
      miscompares++;
      $display("FAIL midcnt_in_reset db7=%b fall=%h rise=%h want 1 0 0", db_out[7], fall, rise);
    end
    @(negedge clk);
    vectors++;
    if (db_out !== 14'h3FFF || fall !== '0) begin
      miscompares++;
      $display("FAIL midcnt_hold db=%h fall=%h want 3fff 0", db_out, fall);
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      vectors++;
      if (db_out !== m_db || rise !== m_rise || fall !== m_fall) begin
        miscompares++;
        $display("FAIL midcnt_model n=%0d db=%h rise=%h fall=%h want %h %h %h",
                 n, db_out, rise, fall, m_db, m_rise, m_fall);
      end
      if (fall[7] === 1'b1) begin
        nf++;
        if (first < 0) first = n;
      end
    end
    vectors++;
    if (nf != 1 || first != 12) begin
      miscompares++;
      $display("FAIL midcnt_restart falls=%0d at=%0d want 1 at 12", nf, first);
    end
    raw_in[7] = 1'b1;
    for (int k = 0; k < 30; k++) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_midcount();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
